// File: rtl/param_sync_ram_clr.sv
// Single-port synchronous RAM with a registered read (latency 1 or 2), an address range check,
// and a clear sequencer that writes CLEAR_VAL to every word after reset and on request.
module param_sync_ram_clr #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 8,
    parameter int                ADDR_W    = 3,
    parameter int                RD_LAT    = 1,
    parameter logic [WIDTH-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              clr,
    output logic              ready,
    output logic [WIDTH-1:0]  r_data,
    output logic              r_valid,
    output logic              addr_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH-1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    logic              in_range;
    logic              req_ok;
    logic              rd_acc;
    logic              addr_err_d;
    logic              addr_err_q;

    logic [WIDTH-1:0]  rd_q;
    logic              rd_oob_q;
    logic              rd_v_q;
    logic [WIDTH-1:0]  rd_s1_data;

    assign in_range = ({1'b0, addr} < DEPTH_EXT);

    // Sequencer and the single write port: the sweep and user writes never overlap.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready     = 1'b0;
        req_ok    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = CLEAR_VAL;
        case (state_q)
            ST_CLEAR: begin
                mem_we = ~rst;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    req_ok = ~rst;
                    if (wen && in_range && !rst) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                        mem_wdata = w_data;
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign rd_acc     = req_ok & ren;
    assign addr_err_d = req_ok & (wen | ren) & ~in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first: the capture sees the word as it was before a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            rd_oob_q <= 1'b0;
            rd_v_q   <= 1'b0;
        end else begin
            rd_v_q <= rd_acc;
            if (rd_acc) begin
                rd_q     <= mem[addr];
                rd_oob_q <= ~in_range;
            end
        end
    end

    assign rd_s1_data = rd_oob_q ? '0 : rd_q;
    assign addr_err   = addr_err_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] r_data_q;
            logic             r_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_v_q;
                    if (rd_v_q) begin
                        r_data_q <= rd_s1_data;
                    end
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end else begin : g_lat1
            assign r_data  = rd_s1_data;
            assign r_valid = rd_v_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_ram_clr.sv
// Drives three RAM configurations with one directed stream and checks every cycle
// against a trace-level model, plus literal expectations for the key scenarios.
module tb_param_sync_ram_clr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] w_data = '0;
    logic       clr = 1'b0;

    logic [2:0] rdy_w;
    logic [2:0] rv_w;
    logic [2:0] ae_w;
    logic [7:0] rd_w [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_sync_ram_clr #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .RD_LAT(1), .CLEAR_VAL(8'hA5)) u0 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .w_data(w_data), .clr(clr),
        .ready(rdy_w[0]), .r_data(rd_w[0]), .r_valid(rv_w[0]), .addr_err(ae_w[0]));

    param_sync_ram_clr #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .RD_LAT(2), .CLEAR_VAL(8'h5A)) u1 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .w_data(w_data), .clr(clr),
        .ready(rdy_w[1]), .r_data(rd_w[1]), .r_valid(rv_w[1]), .addr_err(ae_w[1]));

    param_sync_ram_clr #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .RD_LAT(1), .CLEAR_VAL(8'h00)) u2 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .w_data(w_data), .clr(clr),
        .ready(rdy_w[2]), .r_data(rd_w[2]), .r_valid(rv_w[2]), .addr_err(ae_w[2]));

    function automatic int dep(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic int lat(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [7:0] cval(input int k);
        return (k == 0) ? 8'hA5 : ((k == 1) ? 8'h5A : 8'h00);
    endfunction

    // Model: busy = clear cycles still to run; reads travel through a lat-deep delay.
    logic [7:0] mm [3][8];
    int         busy [3];
    logic       ev [3];
    logic [7:0] ed [3];
    logic       ee [3];
    logic       er [3];
    logic       s1v [3];
    logic [7:0] s1d [3];
    logic       model_ok = 1'b0;

    always @(posedge clk) begin
        logic       capv;
        logic [7:0] capd;
        logic       acc;
        logic       oob;
        logic       nv;
        logic [7:0] nd;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                busy[k] = dep(k);
                ev[k] = 1'b0; ed[k] = 8'h00; ee[k] = 1'b0; er[k] = 1'b0;
                s1v[k] = 1'b0; s1d[k] = 8'h00;
            end else begin
                acc  = (busy[k] == 0) && !clr && (wen || ren);
                oob  = (int'(addr) >= dep(k));
                capv = 1'b0;
                capd = 8'h00;
                if (busy[k] > 0) begin
                    mm[k][dep(k) - busy[k]] = cval(k);
                    busy[k] = busy[k] - 1;
                end else if (clr) begin
                    busy[k] = dep(k);
                end else begin
                    if (ren) begin
                        capv = 1'b1;
                        capd = oob ? 8'h00 : mm[k][addr];
                    end
                    if (wen && !oob) mm[k][addr] = w_data;
                end
                ee[k] = acc && oob;
                if (lat(k) == 1) begin
                    nv = capv; nd = capd;
                end else begin
                    nv = s1v[k]; nd = s1d[k];
                end
                s1v[k] = capv;
                s1d[k] = capd;
                ev[k] = nv;
                if (nv) ed[k] = nd;
                er[k] = (busy[k] == 0);
            end
        end
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                total += 4;
                if (rdy_w[k] !== er[k]) begin
                    bad++;
                    $display("FAIL cmp_ready dut%0d got=%0b want=%0b t=%0t", k, rdy_w[k], er[k], $time);
                end
                if (rv_w[k] !== ev[k]) begin
                    bad++;
                    $display("FAIL cmp_r_valid dut%0d got=%0b want=%0b t=%0t", k, rv_w[k], ev[k], $time);
                end
                if (rd_w[k] !== ed[k]) begin
                    bad++;
                    $display("FAIL cmp_r_data dut%0d got=%02h want=%02h t=%0t", k, rd_w[k], ed[k], $time);
                end
                if (ae_w[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL cmp_addr_err dut%0d got=%0b want=%0b t=%0t", k, ae_w[k], ee[k], $time);
                end
            end
        end
    end

    task automatic tick(input logic w, input logic r, input logic [2:0] a,
                        input logic [7:0] d, input logic c, input logic rs);
        wen = w; ren = r; addr = a; w_data = d; clr = c; rst = rs;
        $display("t=%0t wen=%0b ren=%0b addr=%0d wdata=%02h clr=%0b rst=%0b", $time, w, r, a, d, c, rs);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic count_busy(input string name, input logic w, input logic r);
        int n;
        n = 0;
        while (!rdy_w[0] && n < 50) begin
            n++;
            tick(w, r, 3'd1, 8'h99, 1'b0, 1'b0);
        end
        chk(name, n, 8);
    endtask

    initial begin
        // Reset sweep
        tick(0, 0, 0, 8'h00, 0, 1);
        count_busy("rst_sweep_len", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 3'(i), 8'h00, 0, 0);
            if (i == 0) begin
                chk("rd0_clearval", rd_w[0], 8'hA5);
                chk("rd0_valid", rv_w[0], 1);
            end
        end
        tick(0, 0, 0, 8'h00, 0, 0);

        // Write then read, both latencies
        tick(1, 0, 5, 8'h3C, 0, 0);
        tick(0, 1, 5, 8'h00, 0, 0);
        chk("lat1_data", rd_w[0], 8'h3C);
        chk("lat2_not_yet", rv_w[1], 0);
        tick(0, 0, 0, 8'h00, 0, 0);
        chk("lat2_data", rd_w[1], 8'h3C);
        chk("lat2_valid", rv_w[1], 1);

        // Distinct pattern, back-to-back readback
        for (int i = 0; i < 8; i++) tick(1, 0, 3'(i), 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 1, 3'(i), 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);

        // Read-first collision
        tick(1, 0, 2, 8'h11, 0, 0);
        tick(1, 1, 2, 8'h22, 0, 0);
        chk("collide_old", rd_w[0], 8'h11);
        tick(0, 1, 2, 8'h00, 0, 0);
        chk("collide_new", rd_w[0], 8'h22);

        // Out of range on the six-word instance
        tick(1, 0, 7, 8'h77, 0, 0);
        chk("oob_wr_err", ae_w[2], 1);
        chk("inrange_no_err", ae_w[0], 0);
        tick(0, 1, 6, 8'h00, 0, 0);
        chk("oob_rd_data", rd_w[2], 8'h00);
        chk("oob_rd_valid", rv_w[2], 1);
        chk("oob_rd_err", ae_w[2], 1);
        for (int i = 0; i < 8; i++) tick(0, 1, 3'(i), 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);

        // Runtime clear with a read in flight and writes during the sweep
        for (int i = 0; i < 8; i++) tick(1, 0, 3'(i), 8'hFF, 0, 0);
        tick(0, 1, 3, 8'h00, 0, 0);
        chk("preclear_rd", rd_w[0], 8'hFF);
        tick(0, 0, 0, 8'h00, 1, 0);
        count_busy("clr_sweep_len", 1'b1, 1'b1);
        tick(0, 1, 1, 8'h00, 0, 0);
        chk("wen_in_clear_ignored", rd_w[0], 8'hA5);
        for (int i = 0; i < 8; i++) tick(0, 1, 3'(i), 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);

        // Reset in the fourth cycle of a sweep
        tick(0, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 1);
        chk("rst_ready", rdy_w[0], 0);
        chk("rst_r_data", rd_w[0], 8'h00);
        chk("rst_r_valid", rv_w[0], 0);
        chk("rst_addr_err", ae_w[0], 0);
        count_busy("rst_mid_sweep_len", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(0, 1, 3'(i), 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);
        tick(0, 0, 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
